decrypt_message: RTL

DECRYPT_MESSAGE -- requirements
Module: decrypt_message

---
 rtl/rc4_pkg.sv | 38 +++
 rtl/decrypt_message.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA decrypt block: FSM encoding,
// default message length and the printable-character bounds.
package rc4_pkg;

  localparam int unsigned MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_SPACE = 8'd32;
  localparam logic [7:0] CHAR_LO    = 8'd97;
  localparam logic [7:0] CHAR_HI    = 8'd122;

  // Each memory read is expanded into address / wait / capture states.
  typedef enum logic [4:0] {
    IDLE,
    INC_I,
    RD_SI,
    RD_SI_WAIT,
    RD_SI_CAP,
    RD_SJ,
    RD_SJ_WAIT,
    RD_SJ_CAP,
    WR_SJ,
    WR_SI,
    RD_F,
    RD_F_WAIT,
    RD_F_CAP,
    RD_ROM,
    RD_ROM_WAIT,
    RD_ROM_CAP,
    WR_OUT,
    CHECK,
    DONE
  } state_t;

  function automatic logic char_ok(input logic [7:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
  endfunction

endpackage

// File: rtl/decrypt_message.sv
// RC4 PRGA decryptor: walks an already key-scheduled S array, XORs the
// keystream with ciphertext ROM bytes and writes plaintext RAM.
module decrypt_message
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data,
  output logic       ram_wren,
  output logic       finish,
  output logic       valid
);

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] f_q, f_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_data_q, s_data_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      s_addr_q   <= s_addr_d;
      s_data_q   <= s_data_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    s_addr_d   = s_addr_q;
    s_data_d   = s_data_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INC_I;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          valid_d = 1'b1;
        end
      end
      INC_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = RD_SI;
      end
      RD_SI:      state_d = RD_SI_WAIT;
      RD_SI_WAIT: state_d = RD_SI_CAP;
      RD_SI_CAP: begin
        // Write data for S[j] is loaded now so it is stable well before WR_SJ.
        si_d     = s_q;
        j_d      = j_q + s_q;
        s_addr_d = j_q + s_q;
        s_data_d = s_q;
        state_d  = RD_SJ;
      end
      RD_SJ:      state_d = RD_SJ_WAIT;
      RD_SJ_WAIT: state_d = RD_SJ_CAP;
      RD_SJ_CAP: begin
        sj_d    = s_q;
        state_d = WR_SJ;
      end
      WR_SJ: begin
        s_addr_d = i_q;
        s_data_d = sj_q;
        state_d  = WR_SI;
      end
      WR_SI: begin
        s_addr_d = si_q + sj_q;
        s_data_d = '0;
        state_d  = RD_F;
      end
      RD_F:      state_d = RD_F_WAIT;
      RD_F_WAIT: state_d = RD_F_CAP;
      RD_F_CAP: begin
        f_d        = s_q;
        rom_addr_d = k_q;
        state_d    = RD_ROM;
      end
      RD_ROM:      state_d = RD_ROM_WAIT;
      RD_ROM_WAIT: state_d = RD_ROM_CAP;
      RD_ROM_CAP: begin
        ram_addr_d = k_q;
        ram_data_d = f_q ^ rom_q;
        state_d    = WR_OUT;
      end
      WR_OUT: state_d = CHECK;
      CHECK: begin
        if (!char_ok(ram_data_q)) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INC_I;
        end
      end
      DONE: begin
        if (!start) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_address   = s_addr_q;
  assign s_data      = s_data_q;
  assign s_wren      = (state_q == WR_SJ) || (state_q == WR_SI);
  assign rom_address = rom_addr_q;
  assign ram_address = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = (state_q == WR_OUT);
  assign finish      = (state_q == DONE);
  assign valid       = valid_q;

endmodule
